// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared counting-mode encoding for the up/down counter family.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int COUNT_MODE_W = 2;

    // Encoding 3 is reserved and behaves as WRAP.
    typedef enum logic [COUNT_MODE_W-1:0] {
        WRAP     = 2'd0,
        SATURATE = 2'd1,
        BOUNCE   = 2'd2
    } count_mode_t;

endpackage
`default_nettype wire

// File: rtl/mod_up_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_up_down_counter
//  Description : Modulo up/down counter with wrap, saturate and bounce modes,
//                synchronous load and a registered one-cycle limit flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_up_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = (1 << WIDTH) - 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    direction,
    input  logic [COUNT_MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]        step,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_value,
    output logic [WIDTH-1:0]        count,
    output logic                    at_max,
    output logic                    at_min,
    output logic                    limit_hit,
    output logic                    dir_out
);

    // One spare bit keeps count+step and count+(MAX_VAL+1) from overflowing.
    localparam logic [WIDTH:0]   c_MAX   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   c_MOD   = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] c_MAX_N = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_limit;
    logic             r_dir;

    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_step_raw;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH:0]   w_sum;
    logic             w_bounce;
    logic             w_up;
    logic             w_over;
    logic             w_under;
    logic [WIDTH-1:0] w_wrap_val;
    logic [WIDTH-1:0] w_sat_val;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_limit;
    logic             w_next_dir;

    always_comb begin
        w_cnt_ext  = {1'b0, r_count};
        w_step_raw = {1'b0, step};
        w_step     = (w_step_raw > c_MAX) ? c_MAX : w_step_raw;
        w_load_ext = {1'b0, load_value};
        w_sum      = w_cnt_ext + w_step;
        w_bounce   = (mode == BOUNCE);
        w_up       = w_bounce ? r_dir : direction;
        w_over     = (w_sum > c_MAX);
        w_under    = (w_step > w_cnt_ext);

        if (w_up) begin
            w_wrap_val = w_over ? WIDTH'(w_sum - c_MOD) : WIDTH'(w_sum);
            w_sat_val  = w_over ? c_MAX_N : WIDTH'(w_sum);
        end else begin
            w_wrap_val = w_under ? WIDTH'(w_cnt_ext + c_MOD - w_step)
                                 : WIDTH'(w_cnt_ext - w_step);
            w_sat_val  = w_under ? '0 : WIDTH'(w_cnt_ext - w_step);
        end
    end

    always_comb begin
        w_next_count = r_count;
        w_next_limit = 1'b0;
        // Outside bounce the direction register shadows the input every cycle.
        w_next_dir   = w_bounce ? r_dir : direction;

        if (load) begin
            w_next_count = (w_load_ext > c_MAX) ? c_MAX_N : load_value;
            w_next_dir   = direction;
        end else if (enable && (w_step != '0)) begin
            case (mode)
                SATURATE: begin
                    w_next_count = w_sat_val;
                    w_next_limit = w_up ? w_over : w_under;
                end
                BOUNCE: begin
                    w_next_count = w_sat_val;
                    if (( w_up && (w_sat_val == c_MAX_N)) ||
                        (!w_up && (w_sat_val == '0))) begin
                        w_next_limit = 1'b1;
                        w_next_dir   = ~w_up;
                    end
                end
                default: begin
                    w_next_count = w_wrap_val;
                    w_next_limit = w_up ? w_over : w_under;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_limit <= 1'b0;
            r_dir   <= 1'b1;
        end else begin
            r_count <= w_next_count;
            r_limit <= w_next_limit;
            r_dir   <= w_next_dir;
        end
    end

    assign count     = r_count;
    assign limit_hit = r_limit;
    assign at_max    = (r_count == c_MAX_N);
    assign at_min    = (r_count == '0);
    assign dir_out   = w_up;

endmodule
`default_nettype wire

// File: tb/tb_mod_up_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_up_down_counter
//  Description : Self-checking bench for mod_up_down_counter (WIDTH=4, MAX_VAL=9).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_up_down_counter;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 9;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             direction = 1'b1;
    logic [1:0]       mode = 2'd0;
    logic [WIDTH-1:0] step = '0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             limit_hit;
    logic             dir_out;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference model state
    int m_count = 0;
    bit m_lh    = 1'b0;
    bit m_dir   = 1'b1;
    int m_s;
    int m_raw;
    bit m_bnc;
    bit m_up;

    mod_up_down_counter #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .direction  (direction),
        .mode       (mode),
        .step       (step),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .at_max     (at_max),
        .at_min     (at_min),
        .limit_hit  (limit_hit),
        .dir_out    (dir_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_count = 0;
            m_lh    = 1'b0;
            m_dir   = 1'b1;
        end else begin
            m_s   = (int'(step) > MAX_VAL) ? MAX_VAL : int'(step);
            m_bnc = (mode == 2'd2);
            m_up  = m_bnc ? m_dir : direction;
            if (load) begin
                m_count = (int'(load_value) > MAX_VAL) ? MAX_VAL : int'(load_value);
                m_lh    = 1'b0;
                m_dir   = direction;
            end else begin
                if (enable && m_s != 0) begin
                    m_raw = m_up ? m_count + m_s : m_count - m_s;
                    m_lh  = (m_raw > MAX_VAL) || (m_raw < 0);
                    if (mode == 2'd1 || m_bnc) begin
                        m_count = (m_raw > MAX_VAL) ? MAX_VAL : (m_raw < 0) ? 0 : m_raw;
                        if (m_bnc && ((m_up && m_count == MAX_VAL) || (!m_up && m_count == 0))) begin
                            m_lh  = 1'b1;
                            m_dir = !m_up;
                        end
                    end else begin
                        m_count = (m_raw + MAX_VAL + 1) % (MAX_VAL + 1);
                    end
                end else begin
                    m_lh = 1'b0;
                end
                if (!m_bnc) m_dir = direction;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_count",   int'(count),     m_count);
            check("cyc_limit",   int'(limit_hit), int'(m_lh));
            check("cyc_at_max",  int'(at_max),    int'(m_count == MAX_VAL));
            check("cyc_at_min",  int'(at_min),    int'(m_count == 0));
            check("cyc_dir_out", int'(dir_out),   int'((mode == 2'd2) ? m_dir : direction));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input bit ld, input int lv, input bit en, input int st,
                         input bit dr, input int md);
        load       = ld;
        load_value = WIDTH'(lv);
        enable     = en;
        step       = WIDTH'(st);
        direction  = dr;
        mode       = 2'(md);
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        check("rst_count",  int'(count),     0);
        check("rst_limit",  int'(limit_hit), 0);
        check("rst_at_min", int'(at_min),    1);
        check("rst_at_max", int'(at_max),    0);
        tick();
        reset  = 1'b1;
        cmp_en = 1'b1;

        // WRAP up across the terminal count
        drive(1, 8, 0, 0, 1, 0); tick();
        check("wrap_load", int'(count), 8);
        drive(0, 0, 1, 3, 1, 0); tick();
        check("wrap_up_count", int'(count), 1);
        check("wrap_up_limit", int'(limit_hit), 1);
        drive(0, 0, 0, 3, 1, 0); tick();
        check("wrap_idle_limit", int'(limit_hit), 0);
        check("wrap_idle_count", int'(count), 1);

        // SATURATE down past zero, then landing exactly on zero
        drive(1, 2, 0, 0, 0, 1); tick();
        drive(0, 0, 1, 5, 0, 1); tick();
        check("sat_dn1_count", int'(count), 0);
        check("sat_dn1_limit", int'(limit_hit), 1);
        tick();
        check("sat_dn2_count", int'(count), 0);
        check("sat_dn2_limit", int'(limit_hit), 1);
        drive(1, 4, 0, 0, 0, 1); tick();
        drive(0, 0, 1, 4, 0, 1); tick();
        check("sat_exact_count", int'(count), 0);
        check("sat_exact_limit", int'(limit_hit), 0);

        // BOUNCE seeded up from the tracked direction
        drive(1, 8, 0, 0, 1, 0); tick();
        drive(0, 0, 1, 1, 0, 2); #1;
        check("bnc_dir_before", int'(dir_out), 1);
        tick();
        check("bnc1_count", int'(count), 9);
        check("bnc1_limit", int'(limit_hit), 1);
        check("bnc1_dir", int'(dir_out), 0);
        check("bnc1_at_max", int'(at_max), 1);
        tick();
        check("bnc2_count", int'(count), 8);
        check("bnc2_limit", int'(limit_hit), 0);
        tick();
        check("bnc3_count", int'(count), 7);
        tick();
        check("bnc4_count", int'(count), 6);
        check("bnc4_limit", int'(limit_hit), 0);

        // Asynchronous reset between edges while bouncing down
        drive(1, 7, 0, 0, 0, 2); tick();
        check("bnc_ld_count", int'(count), 7);
        check("bnc_ld_dir", int'(dir_out), 0);
        drive(0, 0, 1, 1, 0, 2);
        #1 reset = 1'b0;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_limit", int'(limit_hit), 0);
        check("arst_dir", int'(dir_out), 1);
        #1 reset = 1'b1;
        tick();
        check("arst_resume", int'(count), 1);

        // Load beats enable; load value clamps
        drive(1, 12, 1, 3, 1, 0); tick();
        check("ld_clamp_count", int'(count), 9);
        check("ld_clamp_limit", int'(limit_hit), 0);
        drive(1, 5, 1, 3, 1, 0); tick();
        check("ld5_count", int'(count), 5);

        // Holds: step 0 and enable low
        drive(1, 6, 0, 0, 1, 0); tick();
        drive(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("step0_count", int'(count), 6);
            check("step0_limit", int'(limit_hit), 0);
        end
        drive(0, 0, 0, 5, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_count", int'(count), 6);
        end

        // Oversized step clamps to MAX_VAL
        drive(1, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 1, 15, 1, 0); tick();
        check("bigstep_count", int'(count), 9);
        check("bigstep_limit", int'(limit_hit), 0);

        // Mode 3 behaves as WRAP
        drive(0, 0, 1, 2, 1, 3); tick();
        check("mode3_count", int'(count), 1);
        check("mode3_limit", int'(limit_hit), 1);

        // Mixed traffic checked by the per-cycle model compare
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
            tick();
        end

        cmp_en = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_up_down_counter.md
MOD_UP_DOWN_COUNTER -- requirements
Module: mod_up_down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1, terminal count (1 <= MAX_VAL <= 2**WIDTH-1).
REQ-003 SHALL have ports:
  clock        input   1      sole clock, rising edge
  reset        input   1      asynchronous, active-low reset
  enable       input   1      step the counter this cycle
  direction    input   1      1 = up, 0 = down (WRAP/SATURATE; BOUNCE seed)
  mode         input   2      count_mode_t: WRAP=0, SATURATE=1, BOUNCE=2, 3 = treated as WRAP
  step         input   WIDTH  increment magnitude
  load         input   1      synchronous load of load_value
  load_value   input   WIDTH  value to load
  count        output  WIDTH  current count, registered
  at_max       output  1      count == MAX_VAL, combinational from count
  at_min       output  1      count == 0, combinational from count
  limit_hit    output  1      registered one-cycle limit-event flag
  dir_out      output  1      effective direction used for the next step

Function
REQ-004 SHALL hold count in the range 0..MAX_VAL at all times.
REQ-005 SHALL use an effective step of min(step, MAX_VAL); step == 0 with enable high SHALL hold count and clear limit_hit.
REQ-006 SHALL evaluate, in priority order: load, then enable, then hold.
REQ-007 On load, SHALL set count to min(load_value, MAX_VAL), clear limit_hit, and set the bounce direction register from direction.
REQ-008 With enable low and load low, SHALL hold count and drive limit_hit to 0 on the next edge.
REQ-009 SHALL compute arithmetic at WIDTH+1 bits so that no intermediate result overflows.
REQ-010 In WRAP mode, counting up SHALL give count+step if that is <= MAX_VAL, else count+step-(MAX_VAL+1), with limit_hit=1 only when wrapped.
REQ-011 In WRAP mode, counting down SHALL give count-step if step <= count, else count+(MAX_VAL+1)-step, with limit_hit=1 only when wrapped.
REQ-012 In SATURATE mode, the result SHALL clamp to MAX_VAL (up) or 0 (down), with limit_hit=1 only when the unclamped result is out of range.
REQ-013 In SATURATE mode, reaching a limit exactly SHALL NOT assert limit_hit.
REQ-014 In BOUNCE mode, SHALL step in the direction held by an internal direction register, clamping as in SATURATE mode.
REQ-015 In BOUNCE mode, when the clamped result equals MAX_VAL going up or 0 going down, SHALL toggle the direction register and assert limit_hit.
REQ-016 While mode != BOUNCE, the direction register SHALL track direction on every cycle, so that entering BOUNCE starts in the direction last driven.
REQ-017 dir_out SHALL equal the direction register in BOUNCE mode, else the direction input.
REQ-018 A change of mode SHALL take effect on the same edge as the step it accompanies; no other state SHALL change.

Reset
REQ-019 When reset is low, SHALL immediately force count=0, limit_hit=0 and direction register=1 (up), without waiting for a clock edge.
REQ-020 Reset deassertion SHALL take effect on the first rising clock edge after it, with normal operation from that edge.
REQ-021 Reset asserted mid-count SHALL abandon any in-flight step; no partial update SHALL be visible.

Structure
REQ-022 SHALL take the count_mode_t enum (WRAP, SATURATE, BOUNCE) from a shared package counter_pkg.
REQ-023 SHALL implement next-state computation combinationally in a single module with one sequential process.
REQ-024 No sub-module is required.

Verification (WIDTH=4, MAX_VAL=9)
REQ-025 WRAP, count=8, step=3, up, enable=1 for 1 cycle -> count=1, limit_hit=1; next idle cycle -> limit_hit=0.
REQ-026 SATURATE, count=2, step=5, down, 2 enabled cycles -> count=0 both cycles, limit_hit=1 both cycles; from count=4, step=4, down -> count=0, limit_hit=0.
REQ-027 BOUNCE entered with direction=1, count=8, step=1, 4 enabled cycles -> count 9,8,7,6; limit_hit=1 on the first cycle only; dir_out goes 1->0 at that edge.
REQ-028 load=1, enable=1, load_value=12 same cycle -> count=9, limit_hit=0; load_value=5 -> count=5.
REQ-029 Asynchronous reset pulse between edges at count=7 in BOUNCE down -> count=0, limit_hit=0, dir_out=1 before the next edge.
REQ-030 step=0 or enable=0 for 3 cycles from count=6 -> count stays 6, limit_hit=0; step=15 up in WRAP from count=0 -> effective step 9, count=9, limit_hit=0.
